pc_predict_unit: RTL and testbench

- Parametrised successor to the current PC-update logic in the pipelined core.
- Holds the fetch PC and selects the next PC by priority: redirect, stall, predicted target, then sequential.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so taken branches can be followed at fetch instead of waiting for MEM-stage resolution.
- Sits between the fetch stage and the EX/MEM branch-resolution logic.

---
 rtl/pc_predict_unit.sv | 179 +++++++++++++++++
 tb/tb_pc_predict_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_predict_unit.sv
// pc_predict_unit: fetch PC register with next-PC selection and a
// direct-mapped branch target buffer (BTB) using 2-bit saturating counters.
// The next PC is chosen by priority: reset, redirect, stall, predicted
// target, then sequential. The BTB is trained by resolved branches from
// the back end of the pipeline.
module pc_predict_unit #(
  parameter int              XLEN        = 64,
  parameter int              BTB_ENTRIES = 16,
  parameter int              TAG_W       = 8,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_write,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  output logic [XLEN-1:0] pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  localparam int IDX_W = (BTB_ENTRIES > 1) ? $clog2(BTB_ENTRIES) : 1;

  // ------------------------------------------------------------------
  // Parameter legality: refuse to elaborate an unusable configuration.
  // ------------------------------------------------------------------
  if ((BTB_ENTRIES < 2) || ((BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0)) begin : g_bad_entries
    $error("pc_predict_unit: BTB_ENTRIES=%0d must be a power of 2 and >= 2", BTB_ENTRIES);
  end

  if ((TAG_W < 1) || ((TAG_W + IDX_W + 2) > XLEN)) begin : g_bad_tag
    $error("pc_predict_unit: TAG_W=%0d does not fit (TAG_W + IDX_W + 2 must be <= XLEN=%0d)",
           TAG_W, XLEN);
  end

  // ------------------------------------------------------------------
  // Address split. Bits [1:0] are the instruction byte offset and are
  // ignored; the index sits directly above them and the tag above that.
  // PC bits above the tag are not stored, so distant PCs may alias.
  // ------------------------------------------------------------------
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  pc_d;
  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;

  assign look_idx = pc_q[IDX_W+1:2];
  assign look_tag = pc_q[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx  = upd_pc[IDX_W+1:2];
  assign upd_tag  = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Byte-offset and above-tag address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{pc_q, upd_pc};

  // ------------------------------------------------------------------
  // BTB storage, one generate slice per entry. Each slice exports its
  // contents onto shared read buses for the combinational lookup.
  // ------------------------------------------------------------------
  logic [BTB_ENTRIES-1:0] ent_valid;
  logic [BTB_ENTRIES-1:0] ent_ctr_hi;
  logic [TAG_W-1:0]       ent_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]        ent_target [BTB_ENTRIES];

  for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
    logic             valid_q;
    logic             valid_d;
    logic [TAG_W-1:0] tag_q;
    logic [TAG_W-1:0] tag_d;
    logic [XLEN-1:0]  target_q;
    logic [XLEN-1:0]  target_d;
    logic [1:0]       ctr_q;
    logic [1:0]       ctr_d;
    logic             sel;
    logic             hit;

    // This entry is trained only when the resolved branch indexes it.
    assign sel = upd_valid && (upd_idx == IDX_W'(gi));
    // A stale tag at this index counts as a miss, never as a hit.
    assign hit = valid_q && (tag_q == upd_tag);

    // Train: counters move toward the outcome, taken misses allocate.
    always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (sel) begin
        if (hit) begin
          if (upd_taken) begin
            target_d = upd_target;
            if (ctr_q != 2'b11) begin
              ctr_d = ctr_q + 2'b01;
            end
          end else if (ctr_q != 2'b00) begin
            ctr_d = ctr_q - 2'b01;
          end
        end else if (upd_taken) begin
          // Replace whatever lived here; start out weakly taken.
          valid_d  = 1'b1;
          tag_d    = upd_tag;
          target_d = upd_target;
          ctr_d    = 2'b10;
        end
      end
    end

    // Only the valid bit is reset; a cleared valid bit masks any update
    // written to the payload on the same edge.
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
      end
    end

    // Payload fields carry no reset so they can map onto plain storage.
    always_ff @(posedge clk) begin
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end

    assign ent_valid[gi]  = valid_q;
    assign ent_ctr_hi[gi] = ctr_q[1];
    assign ent_tag[gi]    = tag_q;
    assign ent_target[gi] = target_q;
  end

  // ------------------------------------------------------------------
  // Lookup: purely combinational from the PC register and the current
  // BTB contents, so a same-edge write is seen only from the next cycle.
  // ------------------------------------------------------------------
  logic             look_hit;
  logic [XLEN-1:0]  look_target;

  assign look_hit    = ent_valid[look_idx] && (ent_tag[look_idx] == look_tag);
  assign look_target = ent_target[look_idx];

  assign pred_hit    = look_hit;
  assign pred_taken  = look_hit && ent_ctr_hi[look_idx];
  assign pred_target = look_hit ? look_target : '0;

  // ------------------------------------------------------------------
  // Next-PC selection. Redirect beats a stall so a misprediction can be
  // recovered even while the front end is held.
  // ------------------------------------------------------------------

  // Pick the next fetch PC by priority.
  always_comb begin
    pc_d = pc_q + XLEN'(4);
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (!pc_write) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_pc_predict_unit.sv
// tb_pc_predict_unit: directed scenarios followed by randomized traffic,
// all checked against a behavioural model of the fetch PC and the BTB.
`timescale 1ns/1ps
module tb_pc_predict_unit;
  localparam int          XLEN   = 64;
  localparam int          NENT   = 16;
  localparam int          TAGW   = 8;
  localparam logic [63:0] RST_PC = 64'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic [63:0] upd_target;
  logic        upd_taken;
  logic [63:0] pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [63:0] pred_target;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_predict_unit #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (NENT),
    .TAG_W       (TAGW),
    .RESET_PC    (RST_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_write    (pc_write),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_target  (upd_target),
    .upd_taken   (upd_taken),
    .pc          (pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target)
  );

  // Reference model: a table of branch records keyed by slot number.
  bit          m_valid  [NENT];
  logic [63:0] m_tag    [NENT];
  logic [63:0] m_target [NENT];
  int          m_ctr    [NENT];
  logic [63:0] m_pc;
  bit          model_known = 1'b0;

  function automatic int slot_of(input logic [63:0] p);
    return int'((p / 64'd4) % 64'(NENT));
  endfunction

  function automatic logic [63:0] tag_of(input logic [63:0] p);
    return (p / 64'(4 * NENT)) % (64'd1 << TAGW);
  endfunction

  function automatic void m_lookup(input logic [63:0] p, output logic hit,
                                   output logic tk, output logic [63:0] tgt);
    int s;
    s   = slot_of(p);
    hit = m_valid[s] && (m_tag[s] == tag_of(p));
    tk  = hit && (m_ctr[s] >= 2);
    tgt = hit ? m_target[s] : 64'h0;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", name, obs, exp);
    end
  endtask

  task automatic check_outs(input string when_s);
    logic        h;
    logic        t;
    logic [63:0] g;
    m_lookup(m_pc, h, t, g);
    chk  ({when_s, " pc"},          pc,          m_pc);
    chk_b({when_s, " pred_hit"},    pred_hit,    h);
    chk_b({when_s, " pred_taken"},  pred_taken,  t);
    chk  ({when_s, " pred_target"}, pred_target, g);
  endtask

  // One clock cycle: drive inputs, check the current lookup, advance the
  // model across the edge, then check the registered result.
  task automatic cyc(input logic rst, input logic pw, input logic rd, input logic [63:0] rpc,
                     input logic uv, input logic [63:0] upc, input logic [63:0] utg,
                     input logic ut);
    logic        h;
    logic        t;
    logic [63:0] g;
    logic [63:0] npc;
    int          s;
    reset = rst; pc_write = pw; redirect = rd; redirect_pc = rpc;
    upd_valid = uv; upd_pc = upc; upd_target = utg; upd_taken = ut;
    #2;
    if (model_known) check_outs("pre");
    @(posedge clk);
    if (rst) begin
      m_pc = RST_PC;
      for (int k = 0; k < NENT; k++) m_valid[k] = 1'b0;
      model_known = 1'b1;
    end else begin
      m_lookup(m_pc, h, t, g);
      if (rd)       npc = rpc;
      else if (!pw) npc = m_pc;
      else if (t)   npc = g;
      else          npc = m_pc + 64'd4;
      if (uv) begin
        s = slot_of(upc);
        if (m_valid[s] && (m_tag[s] == tag_of(upc))) begin
          if (ut) begin
            m_ctr[s]    = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
            m_target[s] = utg;
          end else begin
            m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
          end
        end else if (ut) begin
          m_valid[s]  = 1'b1;
          m_tag[s]    = tag_of(upc);
          m_target[s] = utg;
          m_ctr[s]    = 2;
        end
      end
      m_pc = npc;
    end
    #1;
    $display("cyc rst=%b pw=%b rd=%b rpc=%0h uv=%b upc=%0h utg=%0h ut=%b -> pc=%0h hit=%b tk=%b tgt=%0h",
             rst, pw, rd, rpc, uv, upc, utg, ut, pc, pred_hit, pred_taken, pred_target);
    check_outs("post");
  endtask

  task automatic idle(input logic pw);
    cyc(1'b0, pw, 1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0);
  endtask

  task automatic redir(input logic [63:0] a);
    cyc(1'b0, 1'b0, 1'b1, a, 1'b0, 64'h0, 64'h0, 1'b0);
  endtask

  task automatic train(input logic [63:0] a, input logic [63:0] tgt, input logic tk);
    cyc(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, a, tgt, tk);
  endtask

  function automatic logic [63:0] pick();
    logic [63:0] v;
    if ($urandom_range(0, 1) == 0) v = 64'($urandom_range(0, 31)) << 2;
    else                           v = 64'($urandom_range(0, 4095)) << 2;
    if ($urandom_range(0, 3) == 0) v = v | {32'($urandom), 32'h0};
    return v;
  endfunction

  initial begin
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;

    // Reset and sequential fetch.
    cyc(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0);
    chk  ("reset pc", pc, RST_PC);
    chk_b("reset pred_hit", pred_hit, 1'b0);
    chk_b("reset pred_taken", pred_taken, 1'b0);
    chk  ("reset pred_target", pred_target, 64'h0);
    idle(1'b1);
    chk("seq pc 4", pc, 64'h4);
    idle(1'b1);
    chk("seq pc 8", pc, 64'h8);

    // Stall holds, redirect overrides the stall.
    repeat (3) idle(1'b0);
    chk("stall hold", pc, 64'h8);
    redir(64'h100);
    chk("redirect over stall", pc, 64'h100);

    // Allocate and follow.
    train(64'h10, 64'h40, 1'b1);
    redir(64'h10);
    chk_b("alloc hit", pred_hit, 1'b1);
    chk_b("alloc taken", pred_taken, 1'b1);
    chk  ("alloc target", pred_target, 64'h40);
    idle(1'b1);
    chk("follow target", pc, 64'h40);

    // Hysteresis and saturation.
    train(64'h10, 64'h40, 1'b0);
    redir(64'h10);
    chk_b("weak nt hit", pred_hit, 1'b1);
    chk_b("weak nt taken", pred_taken, 1'b0);
    idle(1'b1);
    chk("weak nt sequential", pc, 64'h14);
    train(64'h10, 64'h80, 1'b1);
    train(64'h10, 64'h80, 1'b1);
    train(64'h10, 64'h80, 1'b1);
    train(64'h10, 64'h80, 1'b0);
    redir(64'h10);
    chk_b("saturate taken", pred_taken, 1'b1);
    chk  ("retarget", pred_target, 64'h80);
    train(64'h10, 64'h80, 1'b0);
    chk_b("step down not taken", pred_taken, 1'b0);

    // Aliasing: 0x50 shares the slot of 0x10 with a different tag.
    train(64'h10, 64'h80, 1'b1);
    redir(64'h50);
    chk_b("alias miss", pred_hit, 1'b0);
    train(64'h50, 64'h900, 1'b0);
    redir(64'h10);
    chk_b("alias nt leaves entry", pred_taken, 1'b1);
    train(64'h50, 64'h200, 1'b1);
    chk_b("alias replaced", pred_hit, 1'b0);
    redir(64'h50);
    chk_b("alias new hit", pred_hit, 1'b1);
    chk  ("alias new target", pred_target, 64'h200);

    // Same-cycle update and lookup.
    redir(64'h20);
    train(64'h20, 64'h300, 1'b1);
    chk_b("same-cycle visible next", pred_hit, 1'b1);
    chk  ("same-cycle target", pred_target, 64'h300);

    // Reset together with an update discards it and empties the BTB.
    cyc(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 64'h30, 64'h400, 1'b1);
    chk  ("reset+upd pc", pc, RST_PC);
    redir(64'h30);
    chk_b("reset+upd discarded", pred_hit, 1'b0);
    redir(64'h50);
    chk_b("reset clears entries", pred_hit, 1'b0);

    // Sequential wrap at the top of the address space.
    redir(64'hFFFF_FFFF_FFFF_FFFC);
    idle(1'b1);
    chk("pc wrap", pc, 64'h0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      a = pick();
      b = pick();
      c = pick();
      cyc(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 7) != 0),
          1'($urandom_range(0, 7) == 0), a, 1'($urandom_range(0, 1)), b, c,
          1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
